// File: rtl/e1b_code_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : e1b_code_loader_pkg
//  Description : Shared constants for the E1B code-memory column loader:
//                code length, RAM geometry, channel-select width and the
//                loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package e1b_code_loader_pkg;

    // Chips per E1B code period (255 full 16-chip words + 12 chips).
    localparam int E1B_CODELEN  = 4092;
    // Address width of the 4096-deep code RAM.
    localparam int E1B_CODEBITS = 12;
    // Number of tracking channels; one RAM bit column per channel.
    localparam int V_GPS_CHANS  = 12;
    // Width of the channel-select field.
    localparam int CH_BITS      = 4;

    // Loader state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_RD    = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/e1b_code_loader.sv
`default_nettype none
// ============================================================================
//  Module      : e1b_code_loader
//  Description : Column-wise loader for the shared E1B code BRAM. A host
//                streams one channel's PRN as 16-chip words; each chip is
//                merged into bit column <ch> of the RAM by a read-modify-write
//                through port A, leaving every other channel's bit intact.
//
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                i_start, i_ch    - load command pulse and target channel
//                i_in_valid/_data - host word stream (bit 0 = earliest chip)
//                o_in_ready       - host word accepted on valid & ready
//                o_ram_addr/_we/_wdata, i_ram_rdata
//                                 - BRAM port A (read latency 1 clk)
//                o_busy           - load in progress
//                o_done           - one-cycle pulse at column completion
//                o_err            - one-cycle pulse on a rejected command
//  Revision    : 1.0 - initial release
// ============================================================================
module e1b_code_loader
    import e1b_code_loader_pkg::*;
#(
    parameter int NCHAN   = V_GPS_CHANS,
    parameter int CODELEN = E1B_CODELEN,
    parameter int ABITS   = E1B_CODEBITS,
    parameter int CHBITS  = CH_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CHBITS-1:0] i_ch,
    input  logic              i_in_valid,
    input  logic [15:0]       i_in_data,
    output logic              o_in_ready,
    output logic [ABITS-1:0]  o_ram_addr,
    output logic              o_ram_we,
    output logic [NCHAN-1:0]  o_ram_wdata,
    input  logic [NCHAN-1:0]  i_ram_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [CHBITS:0]  c_NCHAN     = (CHBITS+1)'(NCHAN);
    localparam logic [ABITS-1:0] c_LAST_CHIP = ABITS'(CODELEN - 1);

    logic [2:0]        r_state;
    logic [CHBITS-1:0] r_ch;
    logic [ABITS-1:0]  r_chip;
    logic [3:0]        r_bit;
    logic [15:0]       r_shreg;
    logic              r_err;

    logic              w_can_start;
    logic              w_ch_ok;
    logic              w_chip_val;
    logic [NCHAN-1:0]  w_merged;

    // DONE behaves like IDLE for command acceptance: the FSM is back in IDLE
    // on the next clock, so a start coinciding with done is taken.
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_ch_ok     = ({1'b0, i_ch} < c_NCHAN);
    assign w_chip_val  = r_shreg[r_bit];

    // Replace only the selected channel's bit in the word read back.
    always_comb begin
        w_merged = i_ram_rdata;
        for (int i = 0; i < NCHAN; i++) begin
            if (CHBITS'(i) == r_ch) begin
                w_merged[i] = w_chip_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_chip  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (i_start) begin
                        if (w_ch_ok) begin
                            r_ch    <= i_ch;
                            r_chip  <= '0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_in_valid) begin
                        r_shreg <= i_in_data;
                        r_bit   <= '0;
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    r_bit <= r_bit + 4'd1;
                    if (r_chip == c_LAST_CHIP) begin
                        // Park the address at 0 so it never shows CODELEN;
                        // the unused tail of the last word is dropped here.
                        r_chip  <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_chip  <= r_chip + 1'b1;
                        r_state <= (r_bit == 4'hF) ? ST_FETCH : ST_RD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A command while a load runs is refused; the load carries on.
            if (i_start && !w_can_start) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_in_ready  = (r_state == ST_FETCH);
    assign o_ram_addr  = r_chip;
    assign o_ram_we    = (r_state == ST_WR);
    assign o_ram_wdata = (r_state == ST_WR) ? w_merged : '0;
    assign o_busy      = !w_can_start;
    assign o_done      = (r_state == ST_DONE);
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_e1b_code_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e1b_code_loader
//  Description : Self-checking bench for e1b_code_loader with a behavioural
//                RAM, a host word feeder and a chip-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_e1b_code_loader;

    localparam int NCHAN   = 12;
    localparam int CODELEN = 4092;
    localparam int DEPTH   = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  i_ch = '0;
    logic        i_in_valid = 1'b0;
    logic [15:0] i_in_data = '0;
    logic        o_in_ready;
    logic [11:0] o_ram_addr;
    logic        o_ram_we;
    logic [11:0] o_ram_wdata;
    logic [11:0] i_ram_rdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    always #5 clk = ~clk;

    e1b_code_loader dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_ch        (i_ch),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_ram_addr  (o_ram_addr),
        .o_ram_we    (o_ram_we),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    // ---------------- code RAM (port A, 1-clk read latency) ----------------
    logic [11:0] mem     [DEPTH];
    logic [11:0] pre_img [DEPTH];
    logic [11:0] snap0   [DEPTH];
    logic [11:0] snap1   [DEPTH];
    logic        pre_en = 1'b0;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pre_img[i];
        end else if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
        end
        i_ram_rdata <= mem[o_ram_addr];
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // The column is a flat chip sequence: chip n comes from word n/16, bit
    // n%16 of the accepted host words. Each accepted word's chips are written
    // 3, 6, 9 ... clocks after its handshake; done follows the final write.
    logic        chk_en = 1'b0;
    logic [11:0] exp_img [DEPTH];
    logic [15:0] m_words [$];
    logic        m_active = 1'b0;
    logic        m_finishing = 1'b0;
    logic        m_err_pend = 1'b0;
    int          m_chip = 0;
    int          m_wait = -1;
    int          m_ch = 0;
    int          we_count = 0;
    int          done_count = 0;

    logic        c_exp_we;
    logic        c_exp_ready;
    logic        c_fin;
    logic [15:0] c_w16;
    logic [11:0] c_word;

    always @(negedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < DEPTH; i++) exp_img[i] = pre_img[i];
        end
        if (chk_en) begin
            c_fin = m_finishing;
            if (m_wait > 0) m_wait--;
            c_exp_we    = (m_wait == 0);
            c_exp_ready = m_active && !m_finishing && (m_chip == 16 * m_words.size());

            check("ram_we",   32'(o_ram_we),   32'(c_exp_we));
            check("in_ready", 32'(o_in_ready), 32'(c_exp_ready));
            check("busy",     32'(o_busy),     32'(m_active && !m_finishing));
            check("done",     32'(o_done),     32'(m_finishing));
            check("err",      32'(o_err),      32'(m_err_pend));
            check("addr_range", 32'(o_ram_addr < 12'(CODELEN)), 32'd1);
            if (o_done) done_count++;

            if (c_exp_we) begin
                c_w16  = m_words[m_chip / 16];
                c_word = exp_img[m_chip];
                c_word[m_ch] = c_w16[m_chip % 16];
                check("ram_addr",  32'(o_ram_addr),  32'(m_chip));
                check("ram_wdata", 32'(o_ram_wdata), 32'(c_word));
                exp_img[m_chip] = c_word;
                m_chip++;
                we_count++;
                if (m_chip == CODELEN) begin
                    m_finishing = 1'b1;
                    m_wait = -1;
                end else if (m_chip % 16 == 0) begin
                    m_wait = -1;
                end else begin
                    m_wait = 3;
                end
            end

            if (c_fin) begin
                m_active = 1'b0;
                m_finishing = 1'b0;
            end

            if (rst) begin
                m_active = 1'b0;
                m_finishing = 1'b0;
                m_wait = -1;
                m_err_pend = 1'b0;
            end else begin
                m_err_pend = 1'b0;
                if (i_start) begin
                    if (i_ch >= 4'(NCHAN) || m_active) begin
                        m_err_pend = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_ch = int'(i_ch);
                        m_chip = 0;
                        m_words.delete();
                        m_wait = -1;
                        we_count = 0;
                    end
                end
                if (c_exp_ready && i_in_valid) begin
                    m_words.push_back(i_in_data);
                    m_wait = 3;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic        feed_abort = 1'b0;
    logic [15:0] rnd_words [256];

    task automatic preload_fill(input logic [11:0] val);
        for (int i = 0; i < DEPTH; i++) pre_img[i] = val;
        pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic preload_snap0();
        for (int i = 0; i < DEPTH; i++) pre_img[i] = snap0[i];
        pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic start_cmd(input logic [3:0] ch);
        i_start = 1'b1;
        i_ch    = ch;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // kind 0: all ones, 1: 16'h5555, 2: random words with random gaps.
    // stall: every third word waits 50 clk after the loader asks for it.
    task automatic feed(input int kind, input bit stall);
        bit hs;
        int budget;
        for (int w = 0; w < 256; w++) begin
            if (feed_abort) break;
            if (stall && (w % 3 == 2)) begin
                budget = 0;
                while (!o_in_ready && !feed_abort && budget < 200) begin
                    @(posedge clk); #1;
                    budget++;
                end
                repeat (50) @(posedge clk);
                #1;
            end else if (kind == 2 && $urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
            i_in_data  = (kind == 0) ? 16'hFFFF : ((kind == 1) ? 16'h5555 : rnd_words[w]);
            i_in_valid = 1'b1;
            hs = 1'b0;
            budget = 0;
            while (!hs && !feed_abort && budget < 200) begin
                hs = o_in_ready;
                @(posedge clk); #1;
                budget++;
            end
            i_in_valid = 1'b0;
            if (!hs && !feed_abort) begin
                fail_now("feed_handshake");
                break;
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!o_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) fail_now(name);
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic check_model_image(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_img[i]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [11:0] t;
        int d0;
        int budget;

        for (int i = 0; i < 256; i++) rnd_words[i] = 16'($urandom);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(o_in_ready),  32'd0);
        check("rst_ram_we",   32'(o_ram_we),    32'd0);
        check("rst_ram_addr", 32'(o_ram_addr),  32'd0);
        check("rst_wdata",    32'(o_ram_wdata), 32'd0);
        check("rst_busy",     32'(o_busy),      32'd0);
        check("rst_done",     32'(o_done),      32'd0);
        check("rst_err",      32'(o_err),       32'd0);
        @(posedge clk); #1;
        chk_en = 1'b1;

        // T1: 12'hAAA background, ch3 all ones
        preload_fill(12'hAAA);
        d0 = done_count;
        start_cmd(4'd3);
        feed(0, 1'b0);
        wait_done("t1_done");
        @(negedge clk);
        check("t1_we_count", 32'(we_count), 32'd4092);
        check("t1_done_once", 32'(done_count - d0), 32'd1);
        check("t1_word0",    32'(mem[0]),    32'hAAA);
        check("t1_word4091", 32'(mem[4091]), 32'hAAA);
        check("t1_word4092", 32'(mem[4092]), 32'hAAA);
        check("t1_word4095", 32'(mem[4095]), 32'hAAA);
        check_model_image("t1_image");
        @(posedge clk); #1;

        // T2: zero background, ch0 <- 5555, then ch11 <- FFFF
        preload_fill(12'h000);
        start_cmd(4'd0);
        feed(1, 1'b0);
        wait_done("t2a_done");
        for (int i = 0; i < DEPTH; i++) snap0[i] = mem[i];
        @(posedge clk); #1;
        start_cmd(4'd11);
        feed(0, 1'b0);
        wait_done("t2b_done");
        @(negedge clk);
        check("t2_word0",    32'(mem[0]),    32'h801);
        check("t2_word1",    32'(mem[1]),    32'h800);
        check("t2_word4090", 32'(mem[4090]), 32'h801);
        check("t2_word4091", 32'(mem[4091]), 32'h800);
        check("t2_word4092", 32'(mem[4092]), 32'h000);
        check_model_image("t2_image");
        for (int i = 0; i < DEPTH; i++) snap1[i] = mem[i];
        @(posedge clk); #1;

        // T3: repeat the ch11 load from the same starting image with stalls
        preload_snap0();
        start_cmd(4'd11);
        feed(0, 1'b1);
        wait_done("t3_done");
        @(negedge clk);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] !== snap1[i]) bad++;
            check("t3_stalled_vs_unstalled", 32'(bad), 32'd0);
        end
        check_model_image("t3_image");
        @(posedge clk); #1;

        // T4: out-of-range channel
        start_cmd(4'd12);
        check("t4_err",  32'(o_err),  32'd1);
        check("t4_busy", 32'(o_busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        start_cmd(4'd15);
        check("t4_err15", 32'(o_err), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // T5: reset after 1000 chips, then a restart with an illegal start
        // injected mid-load
        preload_fill(12'h000);
        start_cmd(4'd7);
        fork
            feed(0, 1'b0);
            begin
                budget = 0;
                while (m_chip < 1000 && budget < 20000) begin
                    @(negedge clk);
                    budget++;
                end
                if (m_chip < 1000) fail_now("t5_reach_1000");
                @(posedge clk); #1;
                rst = 1'b1;
                feed_abort = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("t5_busy_after_rst", 32'(o_busy),   32'd0);
                check("t5_we_after_rst",   32'(o_ram_we), 32'd0);
                @(posedge clk); #1;
            end
        join
        feed_abort = 1'b0;
        t = mem[999];
        check("t5_chip999_written", 32'(t[7]), 32'd1);
        check("t5_chip1000_clean",  32'(mem[1000]), 32'h000);
        check_model_image("t5_partial_image");

        start_cmd(4'd7);
        fork
            feed(2, 1'b0);
            begin
                budget = 0;
                while (m_chip < 300 && budget < 20000) begin
                    @(negedge clk);
                    budget++;
                end
                @(posedge clk); #1;
                start_cmd(4'd2);
                check("t5_busy_start_err", 32'(o_err), 32'd1);
            end
        join
        wait_done("t5_done");
        @(negedge clk);
        check("t5_we_count", 32'(we_count), 32'd4092);
        check_model_image("t5_image");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/e1b_code_loader.md
Name: e1b_code_loader

Overview:
- Column-wise loader for the shared E1B code BRAM, which is 4096 x 12b.
  - Each RAM word holds one chip for every channel: bit n is channel n.
  - The host writes one channel's 4092-chip PRN as a stream of 16-chip words.
- The block performs a read-modify-write of the selected bit column through BRAM port A. Other channels' bits are left untouched.
- Sits between the CPU command interface and port A of the code memory. The port B channel readers are unaffected.

Parameters:
- NCHAN, 12, number of GPS channels (RAM word width); must be <= 16.
- CODELEN, 4092, chips per E1B code period.
- ABITS, 12, RAM address width.
- CHBITS, 4, width of channel select.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse: begin loading column ch
- ch  in  CHBITS  target channel, sampled on start
- in_valid  in  1  host data word valid
- in_data  in  16  16 chips; bit 0 is the earliest chip
- in_ready  out  1  word accepted when in_valid & in_ready
- ram_addr  out  ABITS  port A address
- ram_we  out  1  port A write enable
- ram_wdata  out  NCHAN  port A write data
- ram_rdata  in  NCHAN  port A read data, valid 1 clk after ram_addr
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the column is complete
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset values: in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, err=0. Internal state: IDLE, chip=0, bit=0.
- IDLE
  - start with ch<NCHAN: latch ch, set chip=0, busy=1, go to FETCH.
  - start with ch>=NCHAN: err=1 for one cycle, stay in IDLE.
- FETCH
  - in_ready=1.
  - On handshake, latch in_data into the shift register, set bit=0, go to RD.
- RD: ram_addr=chip, ram_we=0.
- WAIT: hold ram_addr; rdata becomes valid.
- WR
  - ram_we=1, ram_addr=chip.
  - ram_wdata = ram_rdata with bit[ch] replaced by shreg[bit].
  - Then chip++, bit++.
  - If chip was CODELEN-1: go to DONE.
  - Else if bit was 15: go to FETCH.
  - Else: go to RD.
- DONE: done=1, busy=0, go to IDLE.
- Throughput: 3 clk per chip, plus 1 clk per word handshake if in_valid is already high.
  - Full column: 12276 chip cycles + 256 fetch cycles.
- Last word: CODELEN=4092 = 255*16+12, so word 256 uses bits 0..11 only. Bits 12..15 are discarded; no extra word is requested.
- ram_addr never reaches CODELEN. Addresses 4092..4095 are never written.
- in_ready is high only in FETCH. A host stall holds the FSM in FETCH indefinitely, with ram_we=0.
- start while busy: ignored, err=1 for one cycle, the load in progress continues unaffected.
- start and the done cycle coincide: start is accepted, since state is IDLE on the next clk.
- rst mid-load: returns to IDLE on the next clk with ram_we=0. Chips already written stay written; no rollback.
- ram_we is asserted only in WR, exactly once per chip.

Decomposition:
- Shared package/include: E1B_CODELEN, E1B_CODEBITS, V_GPS_CHANS, CH_BITS constants, and the state encoding localparams.
- No sub-module. The FSM, counters and bit-merge fit in one module.
- An optional bit_insert function (word, idx, val) may live in the package.

Test Plan:
- Preload RAM with 12'hAAA everywhere; load ch=3 with all-ones words.
  - Expect every word 0..4091 = 12'hAAA with bit 3 set, i.e. 12'hAAA.
  - Expect 4092..4095 unchanged.
  - Expect done once, after exactly 4092 ram_we pulses.
- Load ch=0 with an alternating pattern (in_data=16'h5555), then ch=11 with 16'hFFFF.
  - Expect word n bit0 = ~n[0], bit11 = 1, other bits preserved.
- Deassert in_valid for 50 clk every third word.
  - Expect the FSM to stall in FETCH with ram_we=0 and no corruption.
  - Expect the final RAM image identical to the unstalled run.
- start with ch=12 -> err pulse, busy stays 0, no RAM activity.
- start during a load -> err pulse, original load completes correctly.
- Assert rst after 1000 chips.
  - Expect busy=0 and ram_we=0 next clk; chips 0..999 written, 1000+ untouched.
  - A restart then completes normally.
